// File: rtl/simon_sequence_player.sv
// Plays the stored Simon colour sequence on four LEDs, one tick lit and one tick dark per step.
// Optional SEQ_PLAYER_SPEEDUP_EN shortens the tick interval as the sequence grows.
module simon_sequence_player #(
  parameter int MAX_LEN   = 32,
  parameter int BASE_LOAD = 25_000_000,
  parameter int STEP_LOAD = 1_000_000,
  parameter int MIN_LOAD  = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  seq_len,
  input  logic        tick,
  output logic [4:0]  seq_rd_addr,
  input  logic [1:0]  seq_rd_data,
  output logic [3:0]  led,
  output logic        timer_enable,
  output logic        timer_reset,
  output logic [24:0] timer_load,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, ARM, ON, OFF, DONE} state_t;

  state_t      state, state_d;
  logic [4:0]  idx, idx_d;
  logic [5:0]  len, len_d;
  logic        last, last_d;
  logic [1:0]  colour, colour_d;
  logic        tick_q;
  logic        tick_edge;
  logic [5:0]  clamped;
  logic [24:0] load_d, load_calc;
  logic [3:0]  led_d;
  logic        done_d, timer_reset_d, timer_enable_d, busy_d;

`ifdef SEQ_PLAYER_SPEEDUP_EN
  localparam logic signed [27:0] BASE_S = 28'(BASE_LOAD);
  localparam logic signed [27:0] STEP_S = 28'(STEP_LOAD);
  localparam logic signed [27:0] MIN_S  = 28'(MIN_LOAD);
  logic signed [27:0] steps_s, reduced_s;

  // Signed arithmetic so an over-long reduction saturates at the floor instead of wrapping
  always_comb begin
    steps_s   = $signed({24'd0, clamped[5:2]});
    reduced_s = BASE_S - steps_s * STEP_S;
    load_calc = (reduced_s < MIN_S) ? 25'(MIN_S) : 25'(reduced_s);
  end
`else
  assign load_calc = 25'(BASE_LOAD);
`endif

  assign tick_edge   = tick & ~tick_q;
  assign clamped     = (seq_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : seq_len;
  assign seq_rd_addr = idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      len          <= '0;
      last         <= 1'b0;
      colour       <= '0;
      tick_q       <= 1'b0;
      led          <= '0;
      done         <= 1'b0;
      timer_reset  <= 1'b0;
      timer_enable <= 1'b0;
      busy         <= 1'b0;
      timer_load   <= 25'(BASE_LOAD);
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      len          <= len_d;
      last         <= last_d;
      colour       <= colour_d;
      tick_q       <= tick;
      led          <= led_d;
      done         <= done_d;
      timer_reset  <= timer_reset_d;
      timer_enable <= timer_enable_d;
      busy         <= busy_d;
      timer_load   <= load_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    len_d    = len;
    last_d   = last;
    load_d   = timer_load;
    done_d   = 1'b0;
    colour_d = (state == ARM || state == OFF) ? seq_rd_data : colour;

    case (state)
      IDLE: begin
        if (start) begin
          if (seq_len == 6'd0) begin
            done_d = 1'b1;
          end else begin
            len_d   = clamped;
            idx_d   = '0;
            last_d  = 1'b0;
            load_d  = load_calc;
            state_d = ARM;
          end
        end
      end
      ARM: state_d = ON;
      ON: begin
        if (tick_edge) begin
          if ({1'b0, idx} == len - 6'd1) last_d = 1'b1;
          else                           idx_d  = 5'(idx + 5'd1);
          state_d = OFF;
        end
      end
      OFF: begin
        if (tick_edge) state_d = last ? DONE : ON;
      end
      DONE: begin
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a tick edge in the same cycle
    if (abort && state != IDLE) begin
      state_d = IDLE;
      last_d  = 1'b0;
    end

    led_d          = (state == ON && !abort) ? (4'b0001 << colour) : 4'b0000;
    done_d         = done_d | (state_d == DONE);
    timer_reset_d  = (state_d == ARM);
    busy_d         = (state_d == ARM) || (state_d == ON) || (state_d == OFF);
    timer_enable_d = busy_d;
  end

endmodule

// File: doc/simon_sequence_player.md
Name: simon_sequence_player

Overview:
- Consumes the periodic tick from the game timer and plays the stored Simon colour sequence on the four LEDs.
- For each step, one colour is lit for one tick interval, then the LEDs are dark for one tick interval.
- Reads colours from the sequence memory through an async-read port.
- Drives the timer's enable, reset and load value, then signals done so the game FSM can hand over to player input.

Parameters:
- MAX_LEN, 32: maximum sequence length (steps).
- BASE_LOAD, 25_000_000: timer load for short sequences (0.5 s at 50 MHz).
- STEP_LOAD, 1_000_000: load reduction per 4 steps of length.
- MIN_LOAD, 5_000_000: floor on timer load.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request playback; sampled only in IDLE.
- abort  in  1  stop playback immediately.
- seq_len  in  6  number of steps to play; latched on start.
- tick  in  1  timer pulse; level input, rising edge detected internally.
- seq_rd_addr  out  5  sequence memory read address.
- seq_rd_data  in  2  colour at seq_rd_addr, valid same cycle (0=G, 1=R, 2=Y, 3=B).
- led  out  4  one-hot colour output; led[c] lit for colour c.
- timer_enable  out  1  high while playback active.
- timer_reset  out  1  one-cycle pulse reloading the timer.
- timer_load  out  25  load value for timer.
- busy  out  1  high in ARM/ON/OFF.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (reset=0, async): state=IDLE, led=0, busy=0, done=0, timer_enable=0, timer_reset=0, idx=0, seq_rd_addr=0, tick_q=0, timer_load=BASE_LOAD.
- tick_edge = tick & ~tick_q. tick_q is registered every cycle.
- seq_rd_addr = idx, registered.
- colour register loads seq_rd_data every cycle in ARM and OFF; holds in ON.
- States:
  - IDLE: led=0.
    - start with seq_len==0: done pulses next cycle, stay IDLE.
    - start with seq_len!=0: latch len=min(seq_len, MAX_LEN), idx=0, update timer_load → ARM.
  - ARM (1 cycle): timer_reset=1, timer_enable=1 → ON.
  - ON: led=onehot(colour).
    - On tick_edge: if idx==len-1 set last flag, else idx++ → OFF.
  - OFF: led=0.
    - On tick_edge: if last → DONE, else → ON.
  - DONE (1 cycle): done=1, timer_enable=0, clear last → IDLE.
- All outputs are registered. The led change occurs the cycle after the state transition.
- Latency: start accepted at edge N → timer_reset high during N+1 → led lit from N+2.
- abort in any non-IDLE state → IDLE next cycle: led=0, no done pulse, timer_enable=0. abort wins over a simultaneous tick_edge. abort in IDLE has no effect.
- start while busy is ignored; seq_len changes while busy are ignored.
- tick held high across several cycles counts as one edge. A tick already high on entry to ON does not count until it falls and rises again.
- MAX_LEN clamp: seq_len=40 plays 32 steps.

Optional Feature:
- SEQ_PLAYER_SPEEDUP_EN defined: timer_load = max(MIN_LOAD, BASE_LOAD − (len>>2)·STEP_LOAD). Computed in ≥27-bit signed arithmetic; no wrap below MIN_LOAD. Registered at start acceptance.
- Not defined: timer_load is constantly BASE_LOAD.

Test Plan:
- Reset mid-ON with led=4'b0100 → all outputs at reset values immediately, no done afterwards.
- seq_len=3, memory {2,0,3}, tick edge every 10 cycles → led sequence 0100, 0000, 0001, 0000, 1000, 0000. done pulses once after the 6th edge. timer_reset pulses once, 1 cycle after start.
- start with seq_len=0 → done pulse 1 cycle later, busy stays 0, led stays 0.
- abort coincident with tick_edge in ON at step 1 of 4 → IDLE, led=0, no done. A new start replays from idx 0.
- tick held high for 5 cycles in ON → exactly one advance. seq_len=40 → exactly 32 ON phases.
- SEQ_PLAYER_SPEEDUP_EN defined: seq_len=8 → timer_load=23_000_000; seq_len=32 → 17_000_000; seq_len=2 → 25_000_000. Undefined: all three give 25_000_000.
